wb_bus_arbiter: RTL and testbench

- Sits directly downstream of the CPU core's two Wishbone masters: instruction-fetch (IWISHBONE) and data/cache (DWISHBONE).
- Arbitrates both masters onto one shared Wishbone slave port that feeds the SoC interconnect (flash/SDRAM/peripherals).
- Ownership is held for a whole cycle (cyc asserted), so cache line fills and store-buffer drains are not interleaved.
- Includes a bus-watchdog that terminates hung transfers with an error strobe.

---
 rtl/wb_bus_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_wb_bus_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// wb_bus_arbiter
//
// Purpose:
//   Arbitrates the CPU's data master (m0, DWISHBONE) and instruction master
//   (m1, IWISHBONE) onto one shared Wishbone slave port. Ownership is held
//   for a whole bus cycle (cyc high), so line fills and store-buffer drains
//   are never interleaved. A bus watchdog ends transfers whose strobe has
//   gone unacknowledged for TIMEOUT cycles by pulsing the owner's err for
//   one cycle.
//
// Handshake:
//   A beat completes in the cycle where the owner's stb_i and s_ack_i are
//   both high. ack/err are combinational, one-cycle pulses and are only
//   ever returned to the current owner. s_ack_i seen while idle or while
//   the owner's stb is low is dropped.
//
// Configuration macro:
//   WB_ARB_ROUND_ROBIN_EN - when defined, the idle-state arbiter favours the
//   master that did not own the bus last. Otherwise m0 always wins.
//
// Ports:
//   clk, rst                   clock (rising edge), synchronous active-high reset
//   m0_*_i / m0_*_o            data master Wishbone port
//   m1_*_i / m1_*_o            instruction master Wishbone port
//   s_*_o / s_data_i, s_ack_i  shared slave port
//   grant_o                    one-hot owner (bit0 = m0, bit1 = m1), 00 = idle
//   dbg_state_o                FSM state (0 idle, 1 own m0, 2 own m1)
//   dbg_cnt_o                  watchdog counter
// ---------------------------------------------------------------------------
module wb_bus_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  // data master
  input  logic [31:0]     m0_addr_i,
  input  logic [31:0]     m0_data_i,
  input  logic            m0_we_i,
  input  logic            m0_stb_i,
  input  logic            m0_cyc_i,
  input  logic [3:0]      m0_sel_i,
  output logic [31:0]     m0_data_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  // instruction master
  input  logic [31:0]     m1_addr_i,
  input  logic [31:0]     m1_data_i,
  input  logic            m1_we_i,
  input  logic            m1_stb_i,
  input  logic            m1_cyc_i,
  input  logic [3:0]      m1_sel_i,
  output logic [31:0]     m1_data_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  // shared slave
  output logic [31:0]     s_addr_o,
  output logic [31:0]     s_data_o,
  output logic            s_we_o,
  output logic            s_stb_o,
  output logic            s_cyc_o,
  output logic [3:0]      s_sel_o,
  input  logic [31:0]     s_data_i,
  input  logic            s_ack_i,
  // status
  output logic [1:0]      grant_o,
  output logic [1:0]      dbg_state_o,
  output logic [TO_W-1:0] dbg_cnt_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_OWN_M0 = 2'd1;
  localparam logic [1:0] ST_OWN_M1 = 2'd2;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic [TO_W-1:0] r_cnt;
  logic            w_own_stb;
  logic            w_fire;

  // Owner's raw strobe; the watchdog looks at this rather than s_stb_o,
  // because s_stb_o is itself suppressed in the cycle the watchdog fires.
  always_comb begin
    w_own_stb = 1'b0;
    case (r_state)
      ST_OWN_M0: w_own_stb = m0_stb_i;
      ST_OWN_M1: w_own_stb = m1_stb_i;
      default:   w_own_stb = 1'b0;
    endcase
  end

  // Ack beats the watchdog when both land in the same cycle.
  assign w_fire = w_own_stb & ~s_ack_i & (r_cnt == TO_LAST);

`ifdef WB_ARB_ROUND_ROBIN_EN
  // 1 = m1 owned last (so m0 is favoured), 0 = m0 owned last.
  logic r_last_owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_owner <= 1'b1;
    end else if (r_state == ST_IDLE) begin
      if (w_next_state == ST_OWN_M0) begin
        r_last_owner <= 1'b0;
      end else if (w_next_state == ST_OWN_M1) begin
        r_last_owner <= 1'b1;
      end
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. Ownership always drops back through IDLE, which
  // guarantees one idle bus cycle between different owners.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
`ifdef WB_ARB_ROUND_ROBIN_EN
        if (m0_cyc_i && m1_cyc_i) begin
          w_next_state = r_last_owner ? ST_OWN_M0 : ST_OWN_M1;
        end else if (m0_cyc_i) begin
          w_next_state = ST_OWN_M0;
        end else if (m1_cyc_i) begin
          w_next_state = ST_OWN_M1;
        end
`else
        if (m0_cyc_i) begin
          w_next_state = ST_OWN_M0;
        end else if (m1_cyc_i) begin
          w_next_state = ST_OWN_M1;
        end
`endif
      end
      ST_OWN_M0: if (!m0_cyc_i) w_next_state = ST_IDLE;
      ST_OWN_M1: if (!m1_cyc_i) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Watchdog counter: counts stalled strobe cycles; any ack, idle strobe,
  // idle state or firing returns it to zero, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst || !w_own_stb || s_ack_i || w_fire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

  // Output logic. Reset forces all bus outputs low so an aborted transfer
  // cannot see an ack in the reset cycle itself.
  always_comb begin
    s_addr_o  = '0;
    s_data_o  = '0;
    s_we_o    = 1'b0;
    s_stb_o   = 1'b0;
    s_cyc_o   = 1'b0;
    s_sel_o   = '0;
    m0_data_o = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_data_o = '0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    grant_o   = 2'b00;
    case (r_state)
      ST_OWN_M0: begin
        grant_o = 2'b01;
        if (!rst) begin
          s_addr_o  = m0_addr_i;
          s_data_o  = m0_data_i;
          s_we_o    = m0_we_i;
          s_sel_o   = m0_sel_i;
          s_cyc_o   = m0_cyc_i;
          s_stb_o   = m0_stb_i & ~w_fire;
          m0_ack_o  = s_ack_i & m0_stb_i;
          m0_err_o  = w_fire;
          m0_data_o = s_data_i;
        end
      end
      ST_OWN_M1: begin
        grant_o = 2'b10;
        if (!rst) begin
          s_addr_o  = m1_addr_i;
          s_data_o  = m1_data_i;
          s_we_o    = m1_we_i;
          s_sel_o   = m1_sel_i;
          s_cyc_o   = m1_cyc_i;
          s_stb_o   = m1_stb_i & ~w_fire;
          m1_ack_o  = s_ack_i & m1_stb_i;
          m1_err_o  = w_fire;
          m1_data_o = s_data_i;
        end
      end
      default: grant_o = 2'b00;
    endcase
  end

  assign dbg_state_o = r_state;
  assign dbg_cnt_o   = r_cnt;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
module tb_wb_bus_arbiter;

  localparam int TIMEOUT = 4;
  localparam int TO_W    = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
  logic            m0_we_i, m0_stb_i, m0_cyc_i, m1_we_i, m1_stb_i, m1_cyc_i;
  logic [3:0]      m0_sel_i, m1_sel_i;
  logic [31:0]     m0_data_o, m1_data_o;
  logic            m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0]     s_addr_o, s_data_o, s_data_i;
  logic            s_we_o, s_stb_o, s_cyc_o, s_ack_i;
  logic [3:0]      s_sel_o;
  logic [1:0]      grant_o, dbg_state_o;
  logic [TO_W-1:0] dbg_cnt_o;

  int total = 0;
  int bad   = 0;

  wb_bus_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_we_i(m0_we_i),
    .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_sel_i(m0_sel_i),
    .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_we_i(m1_we_i),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_sel_i(m1_sel_i),
    .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_sel_o(s_sel_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .dbg_state_o(dbg_state_o), .dbg_cnt_o(dbg_cnt_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // inputs change 1 time unit after the rising edge; checks happen on the
  // falling edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_addr_i = '0; m0_data_i = '0; m0_we_i = 1'b0; m0_stb_i = 1'b0;
    m0_cyc_i  = 1'b0; m0_sel_i = '0;
    m1_addr_i = '0; m1_data_i = '0; m1_we_i = 1'b0; m1_stb_i = 1'b0;
    m1_cyc_i  = 1'b0; m1_sel_i = '0;
    s_data_i  = '0; s_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    @(negedge clk);
    total++;
    if ({grant_o, s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 9'd0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=0",
               {grant_o, s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o});
    end
    total++;
    if ({s_addr_o, s_data_o, s_sel_o, m0_data_o, m1_data_o, dbg_cnt_o} !== '0) begin
      bad++;
      $display("FAIL reset_data got addr=%h data=%h m0d=%h m1d=%h cnt=%0d want all 0",
               s_addr_o, s_data_o, m0_data_o, m1_data_o, dbg_cnt_o);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_addr_i = 32'h0000_00A0; m0_we_i = 1'b1;
    m0_data_i = 32'hCAFE_0001; m0_sel_i = 4'hF;
    step();
    @(negedge clk);
    total++;
    if ({grant_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o} !==
        {2'b01, 1'b1, 1'b1, 1'b1, 4'hF, 32'h0000_00A0, 32'hCAFE_0001}) begin
      bad++;
      $display("FAIL rstmid_grant got grant=%b cyc=%b addr=%h data=%h want 01/1/000000a0/cafe0001",
               grant_o, s_cyc_o, s_addr_o, s_data_o);
    end
    step();
    rst = 1'b1; s_ack_i = 1'b1;
    @(negedge clk);
    total++;
    if (m0_ack_o !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_ack_in_reset got=%b want=0", m0_ack_o);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({grant_o, s_cyc_o, m0_ack_o, dbg_cnt_o} !== {2'b00, 1'b0, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL rstmid_after got grant=%b cyc=%b ack=%b cnt=%0d want 00/0/0/0",
               grant_o, s_cyc_o, m0_ack_o, dbg_cnt_o);
    end
    clear_inputs();
    step();
  endtask

  task automatic test_single_read();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_addr_i = 32'h0000_0100; m1_sel_i = 4'hF;
    @(negedge clk);
    total++;
    if ({grant_o, s_cyc_o} !== 3'b000) begin
      bad++;
      $display("FAIL read_req_cycle got grant=%b cyc=%b want 00/0", grant_o, s_cyc_o);
    end
    step();
    @(negedge clk);
    total++;
    if ({grant_o, s_cyc_o, s_stb_o, s_addr_o, m1_ack_o} !== {2'b10, 1'b1, 1'b1, 32'h0000_0100, 1'b0}) begin
      bad++;
      $display("FAIL read_grant got grant=%b cyc=%b stb=%b addr=%h ack=%b want 10/1/1/00000100/0",
               grant_o, s_cyc_o, s_stb_o, s_addr_o, m1_ack_o);
    end
    step();
    step();
    s_ack_i = 1'b1; s_data_i = 32'h1234_5678;
    @(negedge clk);
    total++;
    if ({m1_ack_o, m1_err_o, m1_data_o, m0_ack_o, m0_data_o} !== {1'b1, 1'b0, 32'h1234_5678, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL read_ack got m1ack=%b m1err=%b m1d=%h m0ack=%b m0d=%h want 1/0/12345678/0/0",
               m1_ack_o, m1_err_o, m1_data_o, m0_ack_o, m0_data_o);
    end
    step();
    s_ack_i = 1'b0; s_data_i = '0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    @(negedge clk);
    total++;
    if ({grant_o, s_cyc_o} !== 3'b100) begin
      bad++;
      $display("FAIL read_release got grant=%b cyc=%b want 10/0", grant_o, s_cyc_o);
    end
    step();
    @(negedge clk);
    total++;
    if (grant_o !== 2'b00) begin
      bad++;
      $display("FAIL read_idle got=%b want=00", grant_o);
    end
  endtask

  task automatic test_contention();
    step();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_addr_i = 32'h0000_0200;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_addr_i = 32'h0000_0300;
    step();
    s_ack_i = 1'b1; s_data_i = 32'h0BAD_F00D;
    @(negedge clk);
    total++;
    if ({grant_o, s_addr_o, m0_ack_o, m1_ack_o} !== {2'b01, 32'h0000_0200, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL cont_grant got grant=%b addr=%h m0ack=%b m1ack=%b want 01/00000200/1/0",
               grant_o, s_addr_o, m0_ack_o, m1_ack_o);
    end
    step();
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    @(negedge clk);
    total++;
    if ({grant_o, s_cyc_o} !== 3'b010) begin
      bad++;
      $display("FAIL cont_release got grant=%b cyc=%b want 01/0", grant_o, s_cyc_o);
    end
    step();
    @(negedge clk);
    total++;
    if ({grant_o, s_cyc_o} !== 3'b000) begin
      bad++;
      $display("FAIL cont_gap got grant=%b cyc=%b want 00/0", grant_o, s_cyc_o);
    end
    step();
    @(negedge clk);
    total++;
    if ({grant_o, s_addr_o} !== {2'b10, 32'h0000_0300}) begin
      bad++;
      $display("FAIL cont_m1 got grant=%b addr=%h want 10/00000300", grant_o, s_addr_o);
    end
    step();
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    step();
  endtask

  task automatic test_burst_hold();
    m0_cyc_i = 1'b1;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_addr_i = 32'h0000_0300;
    step();
    for (int k = 0; k < 4; k++) begin
      m0_stb_i = 1'b1; m0_addr_i = 32'h0000_0400 + 32'(4 * k);
      s_ack_i = 1'b1; s_data_i = 32'h0000_00B0 + 32'(k);
      @(negedge clk);
      total++;
      if ({grant_o, m0_ack_o, m0_data_o, s_addr_o} !==
          {2'b01, 1'b1, 32'h0000_00B0 + 32'(k), 32'h0000_0400 + 32'(4 * k)}) begin
        bad++;
        $display("FAIL burst_beat%0d got grant=%b ack=%b d=%h addr=%h", k, grant_o, m0_ack_o, m0_data_o, s_addr_o);
      end
      step();
      m0_stb_i = 1'b0;
      @(negedge clk);
      total++;
      if ({grant_o, m0_ack_o, m1_ack_o, s_stb_o} !== {2'b01, 1'b0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL burst_gap%0d got grant=%b m0ack=%b m1ack=%b stb=%b want 01/0/0/0",
                 k, grant_o, m0_ack_o, m1_ack_o, s_stb_o);
      end
      step();
    end
    s_ack_i = 1'b0; m0_cyc_i = 1'b0;
    @(negedge clk);
    total++;
    if (grant_o !== 2'b01) begin
      bad++;
      $display("FAIL burst_release got=%b want=01", grant_o);
    end
    step();
    @(negedge clk);
    total++;
    if (grant_o !== 2'b00) begin
      bad++;
      $display("FAIL burst_gap got=%b want=00", grant_o);
    end
    step();
    @(negedge clk);
    total++;
    if (grant_o !== 2'b10) begin
      bad++;
      $display("FAIL burst_m1 got=%b want=10", grant_o);
    end
    step();
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    step();
  endtask

  task automatic test_watchdog();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_addr_i = 32'h0000_0500;
    step();
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      total++;
      if ({s_stb_o, m1_err_o, dbg_cnt_o} !== {1'b1, 1'b0, 8'(i - 1)}) begin
        bad++;
        $display("FAIL wd_stall%0d got stb=%b err=%b cnt=%0d want 1/0/%0d", i, s_stb_o, m1_err_o, dbg_cnt_o, i - 1);
      end
      step();
    end
    @(negedge clk);
    total++;
    if ({m1_err_o, s_stb_o, s_cyc_o, m1_ack_o, m0_err_o} !== 5'b10100) begin
      bad++;
      $display("FAIL wd_fire got err=%b stb=%b cyc=%b ack=%b m0err=%b want 1/0/1/0/0",
               m1_err_o, s_stb_o, s_cyc_o, m1_ack_o, m0_err_o);
    end
    step();
    @(negedge clk);
    total++;
    if ({m1_err_o, s_stb_o, dbg_cnt_o} !== {1'b0, 1'b1, 8'd0}) begin
      bad++;
      $display("FAIL wd_after got err=%b stb=%b cnt=%0d want 0/1/0", m1_err_o, s_stb_o, dbg_cnt_o);
    end
    step();
    step();
    step();
    s_ack_i = 1'b1; s_data_i = 32'h0000_5A5A;
    @(negedge clk);
    total++;
    if ({m1_ack_o, m1_err_o, s_stb_o, m1_data_o} !== {1'b1, 1'b0, 1'b1, 32'h0000_5A5A}) begin
      bad++;
      $display("FAIL wd_ack_wins got ack=%b err=%b stb=%b d=%h want 1/0/1/00005a5a",
               m1_ack_o, m1_err_o, s_stb_o, m1_data_o);
    end
    step();
    s_ack_i = 1'b0; s_data_i = '0;
    @(negedge clk);
    total++;
    if (dbg_cnt_o !== 8'd0) begin
      bad++;
      $display("FAIL wd_ack_clear got=%0d want=0", dbg_cnt_o);
    end
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    step();
    step();
  endtask

  // Both masters keep requesting; each releases for one cycle after an ack.
  // Last owner before this test is m1, so m0 wins the first round either way.
  task automatic test_back_to_back();
    logic [1:0] exp_g;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_addr_i = 32'h0000_0600;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_addr_i = 32'h0000_0700;
    step();
    for (int k = 0; k < 4; k++) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      s_ack_i = 1'b1;
      @(negedge clk);
      total++;
      if ({grant_o, m1_ack_o, m0_ack_o} !== {exp_g, exp_g}) begin
        bad++;
        $display("FAIL b2b_round%0d got grant=%b acks=%b%b want %b", k, grant_o, m1_ack_o, m0_ack_o, exp_g);
      end
      step();
      s_ack_i = 1'b0;
      if (exp_g == 2'b01) begin
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      end else begin
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      end
      step();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      @(negedge clk);
      total++;
      if (grant_o !== 2'b00) begin
        bad++;
        $display("FAIL b2b_gap%0d got=%b want=00", k, grant_o);
      end
      step();
    end
    clear_inputs();
    step();
    step();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_reset_mid();
    test_single_read();
    test_contention();
    test_burst_hold();
    test_watchdog();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
